// File: rtl/pending_encoder_pkg.sv
// Shared definitions for the pending event encoder.
//   DEFAULT_N / DEFAULT_W : default request width and encoded index width
//   slot_state_t          : occupancy of the single-entry output slot
package pending_encoder_pkg;

  localparam int unsigned DEFAULT_N = 8;
  localparam int unsigned DEFAULT_W = $clog2(DEFAULT_N);

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/pending_encoder_prio_encoder.sv
// Combinational lowest-set-bit encoder.
//   vec_i : N-bit input vector
//   idx_o : index of the lowest set bit of vec_i (0 when vec_i is zero)
//   any_o : high when any bit of vec_i is set
module prio_encoder #(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  // Scan from the top down so the last hit is the lowest set bit.
  always_comb begin
    idx_o = '0;
    for (int unsigned i = N; i > 0; i--) begin
      if (vec_i[i-1]) idx_o = W'(i - 1);
    end
  end

  assign any_o = |vec_i;

endmodule

// File: rtl/pending_encoder.sv
// Sequential N:log2(N) priority encoder with a sticky pending register.
//   clk       : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   req       : event pulses, bit i marks event i pending
//   clr_all   : synchronous clear of pending bits, output slot and overflow
//   out_ready : consumer accepts out_idx this cycle
//   out_valid : out_idx holds a valid encoded event
//   out_idx   : binary index of the event in the output slot
//   pending   : pending events not yet moved into the slot
//   overflow  : sticky, an event arrived while its bit was already pending
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [N-1:0] req,
  input  logic         clr_all,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic [N-1:0] pending,
  output logic         overflow
);

  slot_state_t  slot_q, slot_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] out_idx_q, out_idx_d;
  logic         out_valid_q, out_valid_d;
  logic         overflow_q, overflow_d;

  logic [W-1:0] lo_idx;
  logic         lo_any;
  logic         handshake;
  logic         load;
  logic [N-1:0] load_mask;

  prio_encoder #(
    .N (N),
    .W (W)
  ) u_prio (
    .vec_i (pending_q),
    .idx_o (lo_idx),
    .any_o (lo_any)
  );

  assign handshake = out_valid_q & out_ready;
  assign load      = ((slot_q == SLOT_EMPTY) | handshake) & lo_any;
  assign load_mask = load ? (N'(1) << lo_idx) : '0;

  always_comb begin
    slot_d      = slot_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    // The loaded bit leaves pending; a same-cycle req on that bit re-arms it.
    pending_d   = (pending_q & ~load_mask) | req;
    overflow_d  = overflow_q | (|(req & pending_q & ~load_mask));

    if (load) begin
      slot_d      = SLOT_FULL;
      out_valid_d = 1'b1;
      out_idx_d   = lo_idx;
    end else if (handshake) begin
      slot_d      = SLOT_EMPTY;
      out_valid_d = 1'b0;
    end

    if (clr_all) begin
      slot_d      = SLOT_EMPTY;
      out_valid_d = 1'b0;
      pending_d   = '0;
      overflow_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_q      <= SLOT_EMPTY;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      slot_q      <= slot_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pending_encoder.sv
module tb_pending_encoder;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [N-1:0] req;
  logic         clr_all;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [N-1:0] pending;
  logic         overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  pending_encoder #(
    .N (N),
    .W (W)
  ) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .clr_all   (clr_all),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pending   (pending),
    .overflow  (overflow)
  );

  // Reference model: a set of waiting events plus one held slot.
  bit m_pend[N];
  bit m_valid;
  int m_idx;
  bit m_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_valid = 1'b0;
    m_idx   = 0;
    m_ovf   = 1'b0;
  endfunction

  function automatic logic [N-1:0] model_vec();
    logic [N-1:0] v = '0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v[i] = 1'b1;
    return v;
  endfunction

  // One clock edge of the model, using the inputs present at that edge.
  function automatic void model_step(input logic [N-1:0] r, input logic clr, input logic rdy);
    int taken = -1;
    if (clr) begin
      model_reset();
      return;
    end
    if (!m_valid || rdy) begin
      m_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_pend[i] && taken < 0) taken = i;
      end
      if (taken >= 0) begin
        m_valid       = 1'b1;
        m_idx         = taken;
        m_pend[taken] = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        if (m_pend[i]) m_ovf = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
  endfunction

  task automatic compare(input string ph);
    check({ph, " valid"}, 32'(out_valid), 32'(m_valid));
    if (m_valid) check({ph, " idx"}, 32'(out_idx), 32'(m_idx));
    check({ph, " pending"}, 32'(pending), 32'(model_vec()));
    check({ph, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input string ph);
    @(posedge clk);
    if (reset_n) model_step(req, clr_all, out_ready);
    @(negedge clk);
    compare(ph);
  endtask

  task automatic async_reset_pulse(input string ph);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    compare(ph);
    check({ph, " idx0"}, 32'(out_idx), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  int seen3;

  initial begin
    reset_n   = 1'b0;
    req       = 8'hFF;
    clr_all   = 1'b0;
    out_ready = 1'b0;
    model_reset();
    #2;
    compare("rst");
    check("rst idx", 32'(out_idx), 32'd0);
    @(negedge clk);
    @(negedge clk);
    compare("rst held");
    reset_n = 1'b1;
    req     = '0;
    step("post rst");

    // Two events drain lowest first.
    req = 8'b0010_0100; out_ready = 1'b1;
    step("t2 a");
    req = '0;
    step("t2 b");
    check("t2 first idx", 32'(out_idx), 32'd2);
    step("t2 c");
    check("t2 second idx", 32'(out_idx), 32'd5);
    step("t2 d");
    check("t2 drained", 32'(out_valid), 32'd0);

    // Stall holds the slot while a new event queues behind it.
    out_ready = 1'b0; req = 8'h01;
    step("t3 a");
    req = '0;
    step("t3 b");
    for (int i = 0; i < 5; i++) begin
      req = (i == 0) ? 8'h80 : 8'h00;
      step("t3 hold");
      check("t3 hold idx", 32'(out_idx), 32'd0);
    end
    check("t3 pend", 32'(pending), 32'h80);
    req = '0; out_ready = 1'b1;
    step("t3 c");
    check("t3 next idx", 32'(out_idx), 32'd7);
    step("t3 d");

    // Repeat event while pending collapses and flags overflow.
    out_ready = 1'b0; req = 8'h01;
    step("t4 a");
    req = '0;
    step("t4 b");
    req = 8'h08;
    step("t4 c");
    step("t4 d");
    check("t4 ovf", 32'(overflow), 32'd1);
    check("t4 pend", 32'(pending), 32'h08);
    req = '0; out_ready = 1'b1;
    seen3 = 0;
    for (int i = 0; i < 4; i++) begin
      step("t4 drain");
      if (out_valid && out_idx == 3'd3) seen3++;
    end
    check("t4 idx3 once", 32'(seen3), 32'd1);

    // clr_all dominates req and handshake.
    out_ready = 1'b0; req = 8'h10;
    step("t5 a");
    req = '0;
    step("t5 b");
    req = 8'h06;
    step("t5 c");
    check("t5 slot", 32'(out_idx), 32'd4);
    clr_all = 1'b1; req = 8'hFF; out_ready = 1'b1;
    step("t5 clr");
    check("t5 clr valid", 32'(out_valid), 32'd0);
    check("t5 clr ovf", 32'(overflow), 32'd0);
    clr_all = 1'b0; req = '0;
    step("t5 e");

    // Asynchronous reset mid-operation.
    out_ready = 1'b0; req = 8'h04;
    step("t6 a");
    req = '0;
    step("t6 b");
    check("t6 idx", 32'(out_idx), 32'd2);
    async_reset_pulse("t6 rst");
    req = 8'h02;
    step("t6 c");
    req = '0;
    step("t6 d");
    out_ready = 1'b1;
    step("t6 e");

    // Randomised traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      req       = N'($urandom & $urandom & $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      clr_all   = ($urandom_range(0, 99) == 0);
      step("rand");
      if ($urandom_range(0, 299) == 0) async_reset_pulse("rand rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pending_encoder.md
Name: pending_encoder

Overview:
- Sequential N:log2(N) priority encoder; the inverse direction of the team's enabled decoders.
- Collects event bits from N request lines into a sticky pending register.
- Emits one binary index at a time, lowest index first, through a valid/ready output slot.
- Used in the pipelined CPU to turn multi-hot events (exceptions, stall/flush sources) into an encoded cause for downstream logic.

Parameters:
- N, default 8: number of request lines; power of two, N ≥ 2.
- W, default $clog2(N): width of the encoded index.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  event pulses; bit i high for a cycle marks event i pending.
- clr_all  input  1  synchronous clear of pending bits, output slot and overflow.
- out_ready  input  1  consumer accepts out_idx this cycle.
- out_valid  output  1  out_idx holds a valid encoded event.
- out_idx  output  W  binary index of the event in the output slot.
- pending  output  N  current pending register (excludes the index in the slot).
- overflow  output  1  sticky flag: an event arrived while the same bit was already pending.

Behaviour:
- Reset (reset_n low, asynchronous): pending=0, out_valid=0, out_idx=0, overflow=0, slot=SLOT_EMPTY. No clock edge needed.
- Slot FSM states:
  - SLOT_EMPTY → SLOT_FULL when pending≠0.
  - SLOT_FULL stays while out_ready=0.
  - SLOT_FULL with out_ready=1: reload (stay FULL) if pending≠0, else go to SLOT_EMPTY.
- load = (slot empty OR handshake) AND pending≠0; handshake = out_valid & out_ready.
- On load:
  - out_idx ← index of lowest set bit of pending.
  - That bit is cleared from pending in the same edge (moved, not copied).
- Pending update: pending_next = (pending & ~load_mask) | req.
  - req wins over load_mask on the same bit, so a re-arriving event stays pending.
- Latency: req at edge t → pending at t+1 → out_valid at t+2 (slot empty). Throughput: one index per cycle under out_ready=1.
- Stability: while out_valid=1 and out_ready=0, out_valid and out_idx hold constant. out_valid never drops without a handshake except on clr_all or reset.
- Priority: fixed, lowest index first. Starvation of high indices under continuous low-index traffic is accepted.
- Overflow:
  - Set when req[i]=1 and pending[i]=1 and bit i is not being loaded this cycle.
  - Events collapse into the single pending bit.
  - Cleared only by clr_all or reset.
- Same index re-requested while held in the slot: becomes pending again and is reissued after the handshake; not overflow.
- clr_all: next edge pending=0, out_valid=0, overflow=0, slot=SLOT_EMPTY. Dominates req and handshake in that cycle; the handshaked index counts as consumed.
- Reset mid-operation discards all pending events and the slot contents.

Decomposition:
- Package pending_encoder_pkg holds:
  - default N and W;
  - slot_state_t enum {SLOT_EMPTY, SLOT_FULL}.
- Sub-module prio_encoder: combinational lowest-set-bit encoder (inputs: N-bit vector; outputs: W-bit index and any flag).
  - Reusable elsewhere, and exhaustively testable on its own.

Test Plan:
1. Hold reset_n=0, drive req=8'hFF → out_valid=0, pending=8'h00, overflow=0. Release and clock once → still empty.
2. req=8'b0010_0100 for one cycle, out_ready=1 → out_valid=1 with out_idx=2 at t+2, out_idx=5 at t+3, out_valid=0 at t+4, pending=0.
3. out_ready=0, req=8'h01 → out_valid=1, out_idx=0 held for 5 cycles. Meanwhile req=8'h80 → pending=8'h80. Raise out_ready → out_idx=0, then 7, then out_valid=0.
4. Slot holding idx 0 with out_ready=0; req=8'h08 on two consecutive cycles → overflow=1, pending=8'h08. After drain, idx 3 issued exactly once.
5. Slot holding idx 4 with pending=8'h06; assert clr_all with req=8'hFF and out_ready=1 → next cycle pending=0, out_valid=0, overflow=0.
6. out_valid=1, out_idx=2; drop reset_n between clock edges → out_valid, pending and overflow go to 0 before the next edge. Normal operation resumes after release.
